pio_out_multi: RTL and testbench

- Parametrised Avalon-MM output PIO. Successor to the single 6-bit display-control register.
- Provides CHANNELS independent output registers, each WIDTH bits, with atomic set/clear/toggle aliases.
- A shared blink prescaler gates selected bits on and off.
- Drives HEX/LED display enables on the DE1-SoC fabric; sits on the lightweight HPS-to-FPGA bridge.

---
 rtl/pio_out_multi_pkg.sv | 26 ++
 rtl/pio_blink_presc.sv | 40 ++++
 rtl/pio_out_multi.sv | 122 ++++++++++++
 tb/tb_pio_out_multi.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_out_multi_pkg.sv
// Shared definitions for the multi-channel output PIO: register offsets and
// a constant-foldable ceil(log2) helper used to size the channel index.
package pio_out_multi_pkg;

  localparam logic [2:0] OFF_DATA   = 3'd0;
  localparam logic [2:0] OFF_SET    = 3'd1;
  localparam logic [2:0] OFF_CLR    = 3'd2;
  localparam logic [2:0] OFF_TGL    = 3'd3;
  localparam logic [2:0] OFF_BLINK  = 3'd4;
  localparam logic [2:0] OFF_RELOAD = 3'd5;
  localparam logic [2:0] OFF_STATUS = 3'd6;

  // Number of bits needed to index 'value' items (0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pio_blink_presc.sv
// Blink prescaler: global reload register, down-counter and phase flop.
// Phase sits at 1 while reload is 0; otherwise it toggles every reload+1 cycles.
module pio_blink_presc
  import pio_out_multi_pkg::*;
#(
  parameter int PRESC_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               reload_wr,
  input  logic [PRESC_W-1:0] reload_val,
  output logic               blink_phase,
  output logic [PRESC_W-1:0] reload
);

  logic [PRESC_W-1:0] count;

  // Reload write wins over an expiry in the same cycle and restarts phase 1.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      reload      <= '0;
      count       <= '0;
      blink_phase <= 1'b1;
    end else if (reload_wr) begin
      reload      <= reload_val;
      count       <= reload_val;
      blink_phase <= 1'b1;
    end else if (reload == '0) begin
      count       <= '0;
      blink_phase <= 1'b1;
    end else if (count == '0) begin
      count       <= reload;
      blink_phase <= ~blink_phase;
    end else begin
      count       <= count - PRESC_W'(1);
    end
  end

endmodule

// File: rtl/pio_out_multi.sv
// Multi-channel Avalon-MM output PIO with set/clear/toggle aliases and a
// shared blink prescaler. Optional build macro PIO_OUT_MULTI_BYTEEN_EN adds
// a byteenable input that masks every register write.
module pio_out_multi
  import pio_out_multi_pkg::*;
#(
  parameter int               WIDTH     = 6,
  parameter int               CHANNELS  = 1,
  parameter int               PRESC_W   = 24,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CH_AW     = (clog2(CHANNELS) < 1) ? 1 : clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
`ifdef PIO_OUT_MULTI_BYTEEN_EN
  input  logic [3:0]                byteenable,
`endif
  input  logic [CH_AW+2:0]          address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic [CHANNELS*WIDTH-1:0] out_port,
  output logic                      blink_phase
);

  logic [CH_AW-1:0]   ch_idx;
  logic [2:0]         offset;
  logic               wr;
  logic [31:0]        be_mask;
  logic [31:0]        wd_eff;
  logic [WIDTH-1:0]   be_w;
  logic [WIDTH-1:0]   wd_w;
  logic [PRESC_W-1:0] reload;
  logic [PRESC_W-1:0] reload_new;
  logic               reload_wr;
  logic               unused_bits;

  logic [WIDTH-1:0] data_q  [CHANNELS];
  logic [WIDTH-1:0] blink_q [CHANNELS];

  assign ch_idx = address[CH_AW+2:3];
  assign offset = address[2:0];
  assign wr     = chipselect & ~write_n;

`ifdef PIO_OUT_MULTI_BYTEEN_EN
  assign be_mask = {{8{byteenable[3]}}, {8{byteenable[2]}},
                    {8{byteenable[1]}}, {8{byteenable[0]}}};
`else
  assign be_mask = '1;
`endif

  // Disabled bytes read as zero for the aliases and keep old bits on plain writes.
  assign wd_eff     = writedata & be_mask;
  assign be_w       = be_mask[WIDTH-1:0];
  assign wd_w       = wd_eff[WIDTH-1:0];
  assign reload_new = (reload & ~be_mask[PRESC_W-1:0]) | wd_eff[PRESC_W-1:0];

  // The reload register is global; only channel 0's copy accepts writes.
  assign reload_wr  = wr && (ch_idx == '0) && (offset == OFF_RELOAD);

  // Upper writedata bits beyond WIDTH/PRESC_W are intentionally ignored.
  assign unused_bits = ^{wd_eff, be_mask};

  pio_blink_presc #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk         (clk),
    .reset       (reset),
    .reload_wr   (reload_wr),
    .reload_val  (reload_new),
    .blink_phase (blink_phase),
    .reload      (reload)
  );

  // Per-channel data and blink-mask registers with single-cycle RMW aliases.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: these arrays are small flop banks, not RAM, so resetting every entry is cheap and required.
      for (int n = 0; n < CHANNELS; n++) begin
        data_q[n]  <= RESET_VAL;
        blink_q[n] <= '0;
      end
    end else if (wr) begin
      for (int n = 0; n < CHANNELS; n++) begin
        if (ch_idx == CH_AW'(n)) begin
          case (offset)
            OFF_DATA:  data_q[n]  <= (data_q[n] & ~be_w) | wd_w;
            OFF_SET:   data_q[n]  <= data_q[n] | wd_w;
            OFF_CLR:   data_q[n]  <= data_q[n] & ~wd_w;
            OFF_TGL:   data_q[n]  <= data_q[n] ^ wd_w;
            OFF_BLINK: blink_q[n] <= (blink_q[n] & ~be_w) | wd_w;
            default:   ;
          endcase
        end
      end
    end
  end

  // Zero-latency read mux; unmatched channels and the reserved offset read 0.
  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    readdata = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      if (ch_idx == CH_AW'(n)) begin
        case (offset)
          OFF_DATA, OFF_SET, OFF_CLR, OFF_TGL: readdata[WIDTH-1:0] = data_q[n];
          OFF_BLINK:                           readdata[WIDTH-1:0] = blink_q[n];
          OFF_RELOAD:                          readdata[PRESC_W-1:0] = reload;
          OFF_STATUS:                          readdata[0] = blink_phase;
          default:                             ;
        endcase
      end
    end
  end

  // Blink-masked bits drop to 0 during phase 0.
  for (genvar n = 0; n < CHANNELS; n++) begin : g_out
    assign out_port[n*WIDTH +: WIDTH] = data_q[n] & ~(blink_q[n] & {WIDTH{~blink_phase}});
  end

endmodule

// File: tb/tb_pio_out_multi.sv
// Scoreboard bench for pio_out_multi: a 4-channel and a 3-channel instance
// share one bus. Each stimulus slot pushes its expected observations; a
// negedge monitor pops and compares them.
module tb_pio_out_multi;
  import pio_out_multi_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs4, cs3, write_n;
  logic [4:0]  address;
  logic [31:0] writedata;
`ifdef PIO_OUT_MULTI_BYTEEN_EN
  logic [3:0]  byteenable;
`endif
  logic [31:0] readdata4, readdata3;
  logic [23:0] out4;
  logic [17:0] out3;
  logic        ph4, ph3;

  always #5 clk = ~clk;

  pio_out_multi #(.WIDTH(6), .CHANNELS(4), .PRESC_W(8), .RESET_VAL(6'h15)) dut4 (
    .clk(clk), .reset(reset),
`ifdef PIO_OUT_MULTI_BYTEEN_EN
    .byteenable(byteenable),
`endif
    .address(address), .chipselect(cs4), .write_n(write_n), .writedata(writedata),
    .readdata(readdata4), .out_port(out4), .blink_phase(ph4)
  );

  pio_out_multi #(.WIDTH(6), .CHANNELS(3), .PRESC_W(8), .RESET_VAL(6'h00)) dut3 (
    .clk(clk), .reset(reset),
`ifdef PIO_OUT_MULTI_BYTEEN_EN
    .byteenable(byteenable),
`endif
    .address(address), .chipselect(cs3), .write_n(write_n), .writedata(writedata),
    .readdata(readdata3), .out_port(out3), .blink_phase(ph3)
  );

  typedef enum {K_RD4, K_OUT4, K_PH4, K_RD3, K_OUT3, K_PH3} kind_t;
  typedef struct {
    kind_t       kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   obs_cnt  = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] sample(input kind_t k);
    case (k)
      K_RD4:   return readdata4;
      K_OUT4:  return {8'h00, out4};
      K_PH4:   return {31'd0, ph4};
      K_RD3:   return readdata3;
      K_OUT3:  return {14'd0, out3};
      default: return {31'd0, ph3};
    endcase
  endfunction

  // Monitor: pops one expectation per observation requested in this slot.
  always @(negedge clk) begin
    for (int i = 0; i < obs_cnt; i++) begin
      exp_t e;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got empty queue expected an entry at %0t", $time);
      end else begin
        e = sb.pop_front();
        check(e.name, sample(e.kind), e.val);
      end
    end
  end

  // One bus slot: drive just after posedge, observed at the following negedge.
  task automatic bus(input logic rst, input logic c4, input logic c3, input logic wr,
                     input logic [1:0] ch, input logic [2:0] off, input logic [31:0] d);
    @(posedge clk);
    #1;
    reset     = rst;
    cs4       = c4;
    cs3       = c3;
    write_n   = ~wr;
    address   = {ch, off};
    writedata = d;
`ifdef PIO_OUT_MULTI_BYTEEN_EN
    byteenable = 4'hF;
`endif
    obs_cnt   = 0;
  endtask

  task automatic wr4(input logic [1:0] ch, input logic [2:0] off, input logic [31:0] d);
    bus(1'b0, 1'b1, 1'b0, 1'b1, ch, off, d);
  endtask
  task automatic rd4(input logic [1:0] ch, input logic [2:0] off);
    bus(1'b0, 1'b1, 1'b0, 1'b0, ch, off, 32'd0);
  endtask
  task automatic wr3(input logic [1:0] ch, input logic [2:0] off, input logic [31:0] d);
    bus(1'b0, 1'b0, 1'b1, 1'b1, ch, off, d);
  endtask
  task automatic rd3(input logic [1:0] ch, input logic [2:0] off);
    bus(1'b0, 1'b0, 1'b1, 1'b0, ch, off, 32'd0);
  endtask
  task automatic idle();
    bus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 32'd0);
  endtask

  task automatic want(input kind_t k, input logic [31:0] v, input string name);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.name = name;
    sb.push_back(e);
    obs_cnt++;
  endtask

  // Packs four 6-bit channel values into the expected out_port word.
  function automatic logic [31:0] o4(input logic [5:0] c0, input logic [5:0] c1,
                                    input logic [5:0] c2, input logic [5:0] c3);
    return {8'h00, c3, c2, c1, c0};
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1; cs4 = 1'b0; cs3 = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
`ifdef PIO_OUT_MULTI_BYTEEN_EN
    byteenable = 4'hF;
`endif

    // Reset for two cycles
    bus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 32'd0);
    bus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 32'd0);
    want(K_OUT4, 32'h0055_5555, "reset_out4");
    want(K_PH4,  32'd1,         "reset_phase4");
    rd4(2'd2, OFF_DATA);    want(K_RD4, 32'h15, "reset_rd_ch2_data");
    rd4(2'd0, OFF_STATUS);  want(K_RD4, 32'h1,  "reset_status");
    rd4(2'd3, OFF_BLINK);   want(K_RD4, 32'h0,  "reset_blink_ch3");
    rd4(2'd1, OFF_RELOAD);  want(K_RD4, 32'h0,  "reset_reload");
    rd3(2'd0, OFF_DATA);    want(K_RD3, 32'h0,  "reset3_data");
                            want(K_OUT3, 32'h0, "reset3_out");

    // Aliases on channel 1
    wr4(2'd1, OFF_DATA, 32'h0F);
    rd4(2'd1, OFF_DATA);    want(K_RD4, 32'h0F, "alias_data");
                            want(K_OUT4, o4(6'h15, 6'h0F, 6'h15, 6'h15), "alias_data_out");
    wr4(2'd1, OFF_SET, 32'h30);
    rd4(2'd1, OFF_SET);     want(K_RD4, 32'h3F, "alias_set_rd");
                            want(K_OUT4, o4(6'h15, 6'h3F, 6'h15, 6'h15), "alias_set_out");
    wr4(2'd1, OFF_CLR, 32'h03);
    rd4(2'd1, OFF_CLR);     want(K_RD4, 32'h3C, "alias_clr_rd");
                            want(K_OUT4, o4(6'h15, 6'h3C, 6'h15, 6'h15), "alias_clr_out");
    wr4(2'd1, OFF_TGL, 32'h3F);
    rd4(2'd1, OFF_TGL);     want(K_RD4, 32'h03, "alias_tgl_rd");
                            want(K_OUT4, o4(6'h15, 6'h03, 6'h15, 6'h15), "alias_tgl_out");
    wr4(2'd1, OFF_SET, 32'hFFFF_FFC0);
    rd4(2'd1, OFF_DATA);    want(K_RD4, 32'h03, "alias_set_upper_ignored");

    // Blink: reload 3 gives four cycles per phase
    wr4(2'd0, OFF_DATA, 32'h3F);
    wr4(2'd0, OFF_BLINK, 32'h21);
    rd4(2'd0, OFF_BLINK);   want(K_RD4, 32'h21, "blink_mask_rd");
                            want(K_OUT4, o4(6'h3F, 6'h03, 6'h15, 6'h15), "blink_idle_out");
    wr4(2'd0, OFF_RELOAD, 32'h3);
    for (int i = 1; i <= 8; i++) begin
      rd4(2'd0, OFF_STATUS);
      want(K_RD4,  (i <= 4) ? 32'h1 : 32'h0, "blink_status");
      want(K_OUT4, o4((i <= 4) ? 6'h3F : 6'h1E, 6'h03, 6'h15, 6'h15), "blink_out");
    end
    for (int i = 9; i <= 11; i++) begin
      rd4(2'd2, OFF_RELOAD);
      want(K_RD4, 32'h3, "reload_any_channel");
      want(K_PH4, 32'd1, "blink_phase_back");
    end

    // Reload write on the expiry cycle while phase is 1 wins over the toggle
    wr4(2'd0, OFF_RELOAD, 32'h0);
    want(K_PH4, 32'd1, "boundary_pre_phase");
    for (int i = 0; i < 4; i++) begin
      rd4(2'd1, OFF_RELOAD);
      want(K_RD4,  32'h0, "boundary_reload_rd");
      want(K_PH4,  32'd1, "boundary_phase_held");
      want(K_OUT4, o4(6'h3F, 6'h03, 6'h15, 6'h15), "boundary_out_eq_data");
    end

    // Writing reload 0 during phase 0 restores phase 1 immediately
    wr4(2'd0, OFF_RELOAD, 32'h1);
    idle();                 want(K_PH4, 32'd1, "r1_phase_a");
    idle();                 want(K_PH4, 32'd1, "r1_phase_b");
    wr4(2'd0, OFF_RELOAD, 32'h0);
    want(K_PH4, 32'd0, "r1_phase_low");
    want(K_OUT4, o4(6'h1E, 6'h03, 6'h15, 6'h15), "r1_out_low");
    idle();                 want(K_PH4, 32'd1, "r0_phase_restored");
                            want(K_OUT4, o4(6'h3F, 6'h03, 6'h15, 6'h15), "r0_out_restored");

    // Reset while blinking, with a concurrent TGL write that must be lost
    wr4(2'd0, OFF_RELOAD, 32'h2);
    idle();
    idle();
    idle();
    bus(1'b1, 1'b1, 1'b0, 1'b1, 2'd0, OFF_TGL, 32'h3F);
    want(K_PH4,  32'd0, "midreset_pre_phase");
    want(K_OUT4, o4(6'h1E, 6'h03, 6'h15, 6'h15), "midreset_pre_out");
    rd4(2'd0, OFF_DATA);    want(K_RD4,  32'h15, "midreset_write_lost");
                            want(K_OUT4, 32'h0055_5555, "midreset_out");
                            want(K_PH4,  32'd1, "midreset_phase");
    rd4(2'd0, OFF_RELOAD);  want(K_RD4, 32'h0, "midreset_reload");
    rd4(2'd0, OFF_BLINK);   want(K_RD4, 32'h0, "midreset_blink");
    for (int i = 0; i < 3; i++) begin
      idle();               want(K_PH4, 32'd1, "midreset_phase_held");
    end

    // Address range on the 3-channel instance
    wr3(2'd2, OFF_DATA, 32'h11);
    rd3(2'd2, OFF_DATA);    want(K_RD3, 32'h11, "range_ch2_data");
                            want(K_OUT3, 32'h0001_1000, "range_ch2_out");
    wr3(2'd3, OFF_DATA, 32'h2A);
    rd3(2'd3, OFF_DATA);    want(K_RD3, 32'h0, "range_ch3_reads0");
                            want(K_OUT3, 32'h0001_1000, "range_ch3_no_change");
    rd3(2'd0, OFF_DATA);    want(K_RD3, 32'h0, "range_ch0_untouched");
    wr3(2'd3, OFF_BLINK, 32'h3F);
    rd3(2'd3, OFF_BLINK);   want(K_RD3, 32'h0, "range_ch3_blink");
    rd3(2'd2, 3'd7);        want(K_RD3, 32'h0, "reserved_rd_ch2");
    wr3(2'd2, 3'd7, 32'h3F);
    rd3(2'd2, OFF_DATA);    want(K_RD3, 32'h11, "reserved_wr_ignored");
    rd3(2'd0, 3'd7);        want(K_RD3, 32'h0, "reserved_rd_ch0");
    wr3(2'd1, OFF_RELOAD, 32'h5);
    rd3(2'd0, OFF_RELOAD);  want(K_RD3, 32'h0, "reload_ch1_ignored");
                            want(K_PH3, 32'd1, "reload_ch1_phase");
    wr3(2'd0, OFF_RELOAD, 32'hFFFF_FF05);
    rd3(2'd2, OFF_RELOAD);  want(K_RD3, 32'h05, "reload_truncated");
    rd3(2'd3, OFF_RELOAD);  want(K_RD3, 32'h0, "range_ch3_reload");
    rd3(2'd3, OFF_STATUS);  want(K_RD3, 32'h0, "range_ch3_status");

`ifdef PIO_OUT_MULTI_BYTEEN_EN
    // Byte enables: disabled bytes keep old bits or act as zero
    wr4(2'd1, OFF_DATA, 32'h2A); byteenable = 4'b0000;
    rd4(2'd1, OFF_DATA);    want(K_RD4, 32'h15, "be0_data_unchanged");
    wr4(2'd1, OFF_SET, 32'h2A);  byteenable = 4'b0000;
    rd4(2'd1, OFF_DATA);    want(K_RD4, 32'h15, "be0_set_nochange");
    wr4(2'd1, OFF_DATA, 32'h2A); byteenable = 4'b0001;
    rd4(2'd1, OFF_DATA);    want(K_RD4, 32'h2A, "be1_data_written");
    wr3(2'd0, OFF_RELOAD, 32'h0000_0303); byteenable = 4'b0010;
    rd3(2'd0, OFF_RELOAD);  want(K_RD3, 32'h05, "be_reload_byte0_kept");
`endif

    idle();
    idle();
    check("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
